// File: rtl/rr_arb_mux.sv
// NCH:1 valid/ready mux with round-robin grant (fixed priority when RR_ARB_MUX_FIXED_PRIO_EN is defined).
// Latency: 1 cycle through a single output register, one beat per cycle sustained.
// Backpressure: a held beat with out_ready low drops every in_ready and freezes the arbitration pointer.
module rr_arb_mux #(
    parameter int WIDTH = 5,
    parameter int NCH   = 4,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [IDW-1:0]       out_id,
    input  logic                 out_ready
);

    logic             load_en;
    logic             xfer;
    logic             found;
    logic [IDW-1:0]   base;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW:0]     cand;
    logic [WIDTH-1:0] sel_data;

    assign load_en = !out_valid || out_ready;

    // Walk the request vector starting at base, wrapping past NCH-1 back to 0.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = {1'b0, base} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NCH)) begin
                cand = cand - (IDW+1)'(NCH);
            end
            if (!found && in_valid[cand[IDW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[IDW-1:0];
            end
        end
    end

    // rst_n gates the grant so no producer sees an accept while reset is held.
    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && found) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    assign xfer     = |in_ready;
    assign sel_data = in_data[gnt_idx*WIDTH +: WIDTH];

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [IDW-1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (gnt_idx == IDW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign base = ptr;
`endif

    // Data and id only move on a transfer, so a drain leaves the last beat visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_id    <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: constant vector table, directed corner sequences, random traffic vs a reference model.
module tb_rr_arb_mux;

    localparam int WIDTH = 5;
    localparam int NCH   = 4;
    localparam int IDW   = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [IDW-1:0]       out_id;
    logic                 out_ready;

    logic [WIDTH-1:0] dat [NCH];

    int vectors;
    int miscompares;

    // Reference model state
    int               m_ptr;
    logic             m_ov;
    logic [WIDTH-1:0] m_od;
    int               m_oid;

    rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        in_data = '0;
        for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = dat[i];
    end

    typedef struct {
        logic [NCH-1:0]   vld;
        logic             ordy;
        logic [NCH-1:0]   rdy;
        logic             ov;
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] data;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [NCH-1:0] v, input int p);
        for (int k = 0; k < NCH; k++) begin
            if (v[(p + k) % NCH]) return (p + k) % NCH;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_ptr = 0;
        m_ov  = 1'b0;
        m_od  = '0;
        m_oid = 0;
    endfunction

    // One clock: drive at negedge, check in_ready, advance the model at posedge, check outputs.
    task automatic cycle(input logic [NCH-1:0] v, input logic r, output logic [NCH-1:0] got_rdy);
        int w;
        logic [NCH-1:0] er;
        @(negedge clk);
        in_valid  = v;
        out_ready = r;
        #1;
        w  = winner(v, m_ptr);
        er = '0;
        if (w >= 0 && (!m_ov || r)) er[w] = 1'b1;
        got_rdy = in_ready;
        chk("in_ready", 32'(in_ready), 32'(er));
        @(posedge clk);
        if (er != '0) begin
            m_ov  = 1'b1;
            m_od  = dat[w];
            m_oid = w;
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
            m_ptr = (w + 1) % NCH;
`endif
        end else if (r) begin
            m_ov = 1'b0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("out_id", 32'(out_id), 32'(m_oid));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : main
        logic [NCH-1:0] rdy;
        logic [IDW-1:0] rot_id [6];
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = '0;
        out_ready   = 1'b0;
        for (int i = 0; i < NCH; i++) dat[i] = WIDTH'(5'h10 + i);
        model_reset();

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
        rot_id = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        rot_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`endif
        // Rotation under full load, then a 3-cycle stall and release.
        for (int i = 0; i < 6; i++) begin
            tbl[i].vld  = 4'b1111;
            tbl[i].ordy = 1'b1;
            tbl[i].rdy  = 4'b0001 << rot_id[i];
            tbl[i].ov   = 1'b1;
            tbl[i].id   = rot_id[i];
            tbl[i].data = WIDTH'(5'h10 + rot_id[i]);
        end
        for (int i = 6; i < 9; i++) begin
            tbl[i].vld  = 4'b1111;
            tbl[i].ordy = 1'b0;
            tbl[i].rdy  = 4'b0000;
            tbl[i].ov   = 1'b1;
            tbl[i].id   = rot_id[5];
            tbl[i].data = WIDTH'(5'h10 + rot_id[5]);
        end
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
        tbl[9] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 5'h10};
`else
        tbl[9] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 5'h12};
`endif

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].vld, tbl[i].ordy, rdy);
            chk("tbl_rdy", 32'(rdy), 32'(tbl[i].rdy));
            chk("tbl_ov", 32'(out_valid), 32'(tbl[i].ov));
            chk("tbl_id", 32'(out_id), 32'(tbl[i].id));
            chk("tbl_data", 32'(out_data), 32'(tbl[i].data));
        end

        // Reset asserted mid-stall must clear everything before the next edge.
        do_reset();
        cycle(4'b0010, 1'b1, rdy);
        @(negedge clk);
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_out_id", 32'(out_id), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b0100, 1'b1, rdy);
        chk("post_rst_grant", 32'(out_id), 32'd2);

        // Stall/hold with ch1 carrying 5'h1A.
        do_reset();
        dat[1] = 5'h1A;
        cycle(4'b0010, 1'b1, rdy);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1111, 1'b0, rdy);
            chk("stall_rdy", 32'(rdy), 32'd0);
            chk("stall_data", 32'(out_data), 32'h1A);
            chk("stall_id", 32'(out_id), 32'd1);
        end
        cycle(4'b1111, 1'b1, rdy);
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
        chk("stall_release_id", 32'(out_id), 32'd0);
`else
        chk("stall_release_id", 32'(out_id), 32'd2);
`endif

        // Wrap/skip: land the pointer on 3, then only channels 0 and 1 request.
        do_reset();
        cycle(4'b0100, 1'b1, rdy);
        cycle(4'b0011, 1'b1, rdy);
        chk("wrap_id0", 32'(out_id), 32'd0);
        cycle(4'b0011, 1'b1, rdy);
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
        chk("wrap_id1", 32'(out_id), 32'd0);
`else
        chk("wrap_id1", 32'(out_id), 32'd1);
`endif
        cycle(4'b0011, 1'b1, rdy);
        chk("wrap_id2", 32'(out_id), 32'd0);
        cycle(4'b0010, 1'b1, rdy);
        chk("fp_drop0_id", 32'(out_id), 32'd1);

        // Drain without refill.
        do_reset();
        dat[3] = 5'h07;
        cycle(4'b1000, 1'b1, rdy);
        chk("drain_ov1", 32'(out_valid), 32'd1);
        cycle(4'b0000, 1'b1, rdy);
        chk("drain_ov0", 32'(out_valid), 32'd0);
        chk("drain_keep", 32'(out_data), 32'h07);
        cycle(4'b0000, 1'b1, rdy);
        chk("drain_keep2", 32'(out_data), 32'h07);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NCH; i++) dat[i] = WIDTH'($urandom);
            cycle(NCH'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised successor to the fixed 2:1 datapath select: an NCH-way, WIDTH-bit multiplexer with round-robin arbitration and valid/ready handshakes on every channel.
- Output is registered: one pipeline stage, full throughput.
- Sits in front of shared datapath resources (write-back bus, memory port) where several producers compete for one consumer.

Parameters:
- WIDTH, 5, data width per channel in bits (≥1).
- NCH, 4, number of input channels (2..16; non-power-of-2 allowed).
- IDW, 2, width of channel-index field; must satisfy 2^IDW ≥ NCH.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NCH  per-channel request; bit i belongs to channel i.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NCH  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered selected data.
- out_id  output  IDW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_data=0, out_id=0, round-robin pointer ptr=0.
  - in_ready=0 while in reset.
  - A held, undelivered beat is discarded.
- load_en = !out_valid | out_ready.
- Grant (combinational):
  - Search in_valid starting at index ptr, ascending, wrapping NCH-1 → 0.
  - The first set bit wins.
  - in_ready[g] = load_en & in_valid[g] for the winner g; all other bits 0.
  - in_ready may depend combinationally on in_valid and out_ready. Producers must not make in_valid depend on in_ready.
- Transfer (edge where any in_valid & in_ready bit is set):
  - out_data <= channel g data; out_id <= g; out_valid <= 1.
  - ptr <= (g==NCH-1) ? 0 : g+1.
- Drain (out_valid & out_ready, no new transfer): out_valid <= 0. out_data and out_id keep their last values.
- Simultaneous drain and load: new beat replaces the old in the same edge; out_valid stays 1. Sustained throughput is 1 beat/cycle.
- Stall (out_valid & !out_ready):
  - out_data and out_id are held stable; in_ready=0 on all channels.
  - ptr does not move.
- Latency: input beat visible at the output 1 cycle after its transfer edge.
- No valid inputs: no transfer; ptr unchanged.
- Fairness: with all NCH channels continuously valid and out_ready=1, grants rotate 0,1,…,NCH-1,0. Any channel waits at most NCH-1 transfers.
- in_data of non-granted channels has no effect. X on an unselected channel must not propagate to out_data.

Optional Feature:
- Macro: RR_ARB_MUX_FIXED_PRIO_EN.
- Defined:
  - Arbitration is fixed priority: lowest-index valid channel always wins.
  - ptr register is removed (not synthesised).
  - All other handshake and timing rules are unchanged.
- Undefined: round-robin as described above.

Test Plan:
- Reset: assert rst_n=0 mid-stall with out_valid=1 → out_valid=0, out_data=0, out_id=0, in_ready=0 immediately (before next clk edge). After release, in_valid=4'b0100 → first transfer grants channel 2.
- Rotation: NCH=4, in_valid=4'b1111 held, out_ready=1, data ch i = 5'h10+i → out_id sequence 0,1,2,3,0,1 on consecutive cycles; out_data 5'h10,5'h11,5'h12,5'h13,5'h10; out_valid continuously 1.
- Stall/hold: beat ch1 data 5'h1A loaded, out_ready=0 for 3 cycles while in_valid=4'b1111 → out_data=5'h1A, out_id=1 stable; in_ready=0 throughout; ptr stays 2, so the first grant after out_ready=1 is channel 2.
- Wrap/skip: ptr=3, in_valid=4'b0011 → grant channel 0, then channel 1, then channel 0.
- Drain without refill: single beat ch3 data 5'h07, then in_valid=0, out_ready=1 → out_valid high exactly 1 cycle; out_data remains 5'h07 afterward.
- Fixed priority (RR_ARB_MUX_FIXED_PRIO_EN defined): in_valid=4'b1111, out_ready=1 for 4 cycles → out_id 0,0,0,0. Dropping in_valid[0] → out_id=1.
